// File: rtl/proc_defs.sv
// Shared encodings for the 16-bit simple processor control path:
// opcodes, sequencing steps and ALU function codes.
package proc_defs;

  typedef enum logic [1:0] {
    T0 = 2'd0,
    T1 = 2'd1,
    T2 = 2'd2,
    T3 = 2'd3
  } state_t;

  localparam logic [2:0] OP_MV  = 3'b000;
  localparam logic [2:0] OP_MVI = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;
  localparam logic [2:0] OP_AND = 3'b100;
  localparam logic [2:0] OP_OR  = 3'b101;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_OR  = 2'b11;

  function automatic logic is_alu_op(input logic [2:0] op);
    logic res;
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR: res = 1'b1;
      default:                       res = 1'b0;
    endcase
    return res;
  endfunction

  // Flipping bit 1 of the low opcode bits lands add/sub/and/or on 00/01/10/11.
  function automatic logic [1:0] alu_code(input logic [2:0] op);
    return op[1:0] ^ 2'b10;
  endfunction

endpackage

// File: rtl/control_unit_if.sv
// Handshake and control bundle between the sequencer and the datapath
// (bus mux, register file, A/G registers, ALU).
interface control_unit_if #(
  parameter int DIN_WIDTH = 16
) ();

  logic                 Run;
  logic [DIN_WIDTH-1:0] DIN;
  logic [7:0]           Rout;
  logic [7:0]           Rin;
  logic                 Gout;
  logic                 DINout;
  logic                 Ain;
  logic                 Gin;
  logic [1:0]           AluOp;
  logic                 Done;
  logic                 Busy;

  modport master (
    output Run, DIN,
    input  Rout, Rin, Gout, DINout, Ain, Gin, AluOp, Done, Busy
  );

  modport slave (
    input  Run, DIN,
    output Rout, Rin, Gout, DINout, Ain, Gin, AluOp, Done, Busy
  );

endinterface

// File: rtl/control_unit_dec3to8.sv
// 3-to-8 one-hot decoder with enable; index 0 maps to the MSB so that
// bit 7 selects R0 and bit 0 selects R7.
module dec3to8 (
  input  logic       en,
  input  logic [2:0] idx,
  output logic [7:0] onehot
);

  // Shift a single MSB marker down by the register index.
  always_comb begin
    onehot = 8'b0000_0000;
    if (en) begin
      onehot = 8'b1000_0000 >> idx;
    end else begin
      onehot = 8'b0000_0000;
    end
  end

endmodule

// File: rtl/control_unit.sv
// Sequencing FSM for the 16-bit simple processor: captures an instruction
// in T0 and decodes T1..T3 into bus-source selects and register enables.
module control_unit
  import proc_defs::*;
#(
  parameter int DIN_WIDTH = 16
) (
  input  logic              Clock,
  input  logic              Resetn,
  control_unit_if.slave     bus
);

  state_t     state_q, state_d;
  logic [8:0] ir_q, ir_d;

  logic [2:0] op_s, x_s, y_s;
  logic       rout_en_s, rin_en_s;
  logic [2:0] rout_idx_s;
  logic [7:0] rout_s, rin_s;
  logic       gout_s, dinout_s, ain_s, gin_s, done_s;
  logic [1:0] aluop_s;
  logic       unused_din_s;

  assign op_s = ir_q[8:6];
  assign x_s  = ir_q[5:3];
  assign y_s  = ir_q[2:0];

  // Only the low nine bits of DIN carry an instruction.
  assign unused_din_s = ^bus.DIN[DIN_WIDTH-1:9];

  // Next-state and instruction capture; Run is only looked at in T0.
  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    case (state_q)
      T0: begin
        if (bus.Run) begin
          ir_d    = bus.DIN[8:0];
          state_d = T1;
        end else begin
          state_d = T0;
        end
      end
      T1: begin
        if (is_alu_op(op_s)) begin
          state_d = T2;
        end else begin
          state_d = T0;
        end
      end
      T2:      state_d = T3;
      T3:      state_d = T0;
      default: state_d = T0;
    endcase
  end

  // State and IR registers.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q <= T0;
      ir_q    <= 9'd0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
    end
  end

  // Moore output decode; at most one bus source is ever selected per step.
  always_comb begin
    rout_en_s  = 1'b0;
    rout_idx_s = 3'd0;
    rin_en_s   = 1'b0;
    gout_s     = 1'b0;
    dinout_s   = 1'b0;
    ain_s      = 1'b0;
    gin_s      = 1'b0;
    aluop_s    = ALU_ADD;
    done_s     = 1'b0;
    case (state_q)
      T0: begin
        done_s = 1'b0;
      end
      T1: begin
        case (op_s)
          OP_MV: begin
            rout_en_s  = 1'b1;
            rout_idx_s = y_s;
            rin_en_s   = 1'b1;
            done_s     = 1'b1;
          end
          OP_MVI: begin
            dinout_s = 1'b1;
            rin_en_s = 1'b1;
            done_s   = 1'b1;
          end
          OP_ADD, OP_SUB, OP_AND, OP_OR: begin
            rout_en_s  = 1'b1;
            rout_idx_s = x_s;
            ain_s      = 1'b1;
          end
          default: begin
            done_s = 1'b1;
          end
        endcase
      end
      T2: begin
        rout_en_s  = 1'b1;
        rout_idx_s = y_s;
        gin_s      = 1'b1;
        aluop_s    = alu_code(op_s);
      end
      T3: begin
        gout_s   = 1'b1;
        rin_en_s = 1'b1;
        done_s   = 1'b1;
      end
      default: begin
        done_s = 1'b0;
      end
    endcase
  end

  dec3to8 u_rout_dec (
    .en     (rout_en_s),
    .idx    (rout_idx_s),
    .onehot (rout_s)
  );

  dec3to8 u_rin_dec (
    .en     (rin_en_s),
    .idx    (x_s),
    .onehot (rin_s)
  );

  assign bus.Rout   = rout_s;
  assign bus.Rin    = rin_s;
  assign bus.Gout   = gout_s;
  assign bus.DINout = dinout_s;
  assign bus.Ain    = ain_s;
  assign bus.Gin    = gin_s;
  assign bus.AluOp  = aluop_s;
  assign bus.Done   = done_s;
  assign bus.Busy   = (state_q != T0);

endmodule

// File: tb/tb_control_unit.sv
// Scoreboard bench for control_unit: the driver pushes the hand-computed
// per-cycle output vector, a negedge monitor pops and compares it.
module tb_control_unit;

  typedef struct packed {
    logic [7:0] rout;
    logic [7:0] rin;
    logic       gout;
    logic       dinout;
    logic       ain;
    logic       gin;
    logic [1:0] aluop;
    logic       done;
    logic       busy;
  } out_t;

  logic Clock;
  logic Resetn;

  control_unit_if #(.DIN_WIDTH(16)) bus_if ();

  control_unit #(.DIN_WIDTH(16)) dut (
    .Clock  (Clock),
    .Resetn (Resetn),
    .bus    (bus_if.slave)
  );

  out_t  exp_q[$];
  string name_q[$];
  int    checks = 0;
  int    errors = 0;

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  function automatic out_t mk(input logic [7:0] ro, input logic [7:0] ri,
                              input logic go, input logic di, input logic a,
                              input logic g, input logic [1:0] op,
                              input logic d, input logic b);
    out_t o;
    o.rout = ro; o.rin = ri; o.gout = go; o.dinout = di; o.ain = a;
    o.gin = g; o.aluop = op; o.done = d; o.busy = b;
    return o;
  endfunction

  function automatic out_t cur();
    return mk(bus_if.Rout, bus_if.Rin, bus_if.Gout, bus_if.DINout, bus_if.Ain,
              bus_if.Gin, bus_if.AluOp, bus_if.Done, bus_if.Busy);
  endfunction

  task automatic check(input string name, input out_t act, input out_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h (rout=%b rin=%b) expected %h (rout=%b rin=%b)",
               name, act, act.rout, act.rin, exp, exp.rout, exp.rin);
    end
  endtask

  // Monitor: bus exclusivity every cycle, and scoreboard pop when pending.
  always @(negedge Clock) begin
    int srcs;
    srcs = int'(bus_if.Rout != 8'h00) + int'(bus_if.Gout) + int'(bus_if.DINout);
    checks++;
    if (srcs > 1) begin
      errors++;
      $display("FAIL bus_excl: got %0d sources, expected at most 1", srcs);
    end
    if (exp_q.size() > 0) begin
      check(name_q.pop_front(), cur(), exp_q.pop_front());
    end
  end

  // One cycle: apply inputs just after the edge and queue that cycle's outputs.
  task automatic cyc(input logic run, input logic [15:0] din, input out_t e,
                     input string name);
    exp_q.push_back(e);
    name_q.push_back(name);
    bus_if.Run = run;
    bus_if.DIN = din;
    @(posedge Clock);
    #1;
  endtask

  out_t idle;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    idle = mk(8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
    Resetn = 1'b0;
    bus_if.Run = 1'b0;
    bus_if.DIN = 16'h0000;
    @(posedge Clock);
    #1;
    cyc(1'b1, 16'h0007, idle, "reset_hold");
    Resetn = 1'b1;
    cyc(1'b0, 16'h0000, idle, "reset_idle");

    // mvi R5,#0x00A3
    cyc(1'b1, 16'h0068, idle, "mvi_t0");
    cyc(1'b0, 16'h00A3, mk(8'h00, 8'b0000_0100, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b1, 1'b1), "mvi_t1");
    // mv R0,R7 issued back-to-back right after Done
    cyc(1'b1, 16'h0007, idle, "mv_t0");
    cyc(1'b0, 16'h0000, mk(8'b0000_0001, 8'b1000_0000, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 1'b1), "mv_t1");
    cyc(1'b0, 16'h0000, idle, "mv_after");

    // sub R3,R6
    cyc(1'b1, 16'h00DE, idle, "sub_t0");
    cyc(1'b0, 16'h0000, mk(8'b0001_0000, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b1), "sub_t1");
    cyc(1'b0, 16'h0000, mk(8'b0000_0010, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 1'b0, 1'b1), "sub_t2");
    cyc(1'b0, 16'h0000, mk(8'h00, 8'b0001_0000, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 1'b1), "sub_t3");
    cyc(1'b0, 16'h0000, idle, "sub_after");

    // reserved 111_010_001
    cyc(1'b1, 16'h01D1, idle, "nop_t0");
    cyc(1'b0, 16'h0000, mk(8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 1'b1), "nop_t1");
    cyc(1'b0, 16'h0000, idle, "nop_after");

    // and R2,R4 then or R6,R1; Run/DIN wiggle mid-instruction must not touch IR
    cyc(1'b1, 16'h0114, idle, "and_t0");
    cyc(1'b1, 16'h0171, mk(8'b0010_0000, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b1), "and_t1");
    cyc(1'b0, 16'hFFFF, mk(8'b0000_1000, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 1'b0, 1'b1), "and_t2");
    cyc(1'b1, 16'h0171, mk(8'h00, 8'b0010_0000, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 1'b1), "and_t3");
    cyc(1'b1, 16'h0171, idle, "or_t0");
    cyc(1'b1, 16'h0007, mk(8'b0000_0010, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b1), "or_t1");
    cyc(1'b1, 16'h0000, mk(8'b0100_0000, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 2'b11, 1'b0, 1'b1), "or_t2");
    cyc(1'b0, 16'h0000, mk(8'h00, 8'b0000_0010, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 1'b1), "or_t3");
    cyc(1'b0, 16'h0000, idle, "or_after");

    // add R1,R2 with reset pulled in T2
    cyc(1'b1, 16'h008A, idle, "add_t0");
    cyc(1'b0, 16'h0000, mk(8'b0100_0000, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b1), "add_t1");
    exp_q.push_back(mk(8'b0010_0000, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 1'b1));
    name_q.push_back("add_t2");
    @(negedge Clock);
    #1;
    Resetn = 1'b0;
    #1;
    check("reset_async", cur(), idle);
    @(posedge Clock);
    #1;
    Resetn = 1'b1;
    cyc(1'b0, 16'h008A, idle, "post_reset_idle0");
    cyc(1'b0, 16'h008A, idle, "post_reset_idle1");

    @(negedge Clock);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
